emu_burst_tester: RTL and testbench

- Parametrised co-emulation chip-test wrapper.
- Sits between the emulation host bus (Din_emu/Dout_emu/Addr_emu) and the pins of an arbitrary DUT.
- Generalises the fixed 2-byte stimulus/capture wrapper to N-byte vectors.
- Adds an autonomous burst mode: the block generates K DUT clock cycles itself and captures DUT outputs every cycle into an on-chip buffer for later host readback.

---
 rtl/emu_burst_tester_pkg.sv | 50 +++++
 rtl/emu_burst_tester_if.sv | 31 +++
 rtl/emu_burst_tester_capture_buf.sv | 51 +++++
 rtl/emu_burst_tester.sv | 185 ++++++++++++++++++
 tb/tb_emu_burst_tester.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/emu_burst_tester_pkg.sv
// rtl/emu_burst_tester_pkg.sv - shared types, constants and byte helpers for emu_burst_tester
// Package emu_tester_pkg (no ports):
//   state_e   burst FSM states
//   cmd_e     decoded host command, ordered by priority
//   bytes_of  byte count needed for a pin vector
//   get_byte / put_byte  byte-lane access on a padded vector (pin i -> byte i/8, bit i%8)
package emu_tester_pkg;

   typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_e;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_LOAD,
      CMD_GET,
      CMD_RUN,
      CMD_POP,
      CMD_WR
   } cmd_e;

   // Widest vector the byte helpers handle; host addressing never exceeds this.
   localparam int MAX_VEC_W = 128;
   typedef logic [MAX_VEC_W-1:0] vec_t;

   function automatic int bytes_of(input int width);
      return (width + 7) / 8;
   endfunction

   // Only one action per cycle: load > get > run > pop > wr.
   function automatic cmd_e cmd_pick(input logic load, input logic get, input logic run,
                                     input logic pop, input logic wr);
      if (load)     return CMD_LOAD;
      else if (get) return CMD_GET;
      else if (run) return CMD_RUN;
      else if (pop) return CMD_POP;
      else if (wr)  return CMD_WR;
      return CMD_NONE;
   endfunction

   function automatic logic [7:0] get_byte(input vec_t v, input int unsigned idx);
      return v[idx*8 +: 8];
   endfunction

   function automatic vec_t put_byte(input vec_t v, input int unsigned idx, input logic [7:0] b);
      vec_t r;
      r = v;
      r[idx*8 +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/emu_burst_tester_if.sv
// rtl/emu_burst_tester_if.sv - host bus interface of emu_burst_tester
// Signals: Din_emu, Addr_emu, wr/load/get/run/pop strobes (host -> tester),
//          Dout_emu, busy_emu, done_emu (tester -> host);
//          with EMU_BURST_TESTER_CMP_EN also mismatch_emu, mis_cnt_emu.
// Modports: master (host side), slave (tester side).
interface emu_burst_tester_if #(parameter int ADDR_W = 4);
   logic [7:0]        Din_emu;
   logic [ADDR_W-1:0] Addr_emu;
   logic              wr_emu;
   logic              load_emu;
   logic              get_emu;
   logic              run_emu;
   logic              pop_emu;
   logic [7:0]        Dout_emu;
   logic              busy_emu;
   logic              done_emu;
`ifdef EMU_BURST_TESTER_CMP_EN
   logic              mismatch_emu;
   logic [7:0]        mis_cnt_emu;

   modport master (output Din_emu, Addr_emu, wr_emu, load_emu, get_emu, run_emu, pop_emu,
                   input  Dout_emu, busy_emu, done_emu, mismatch_emu, mis_cnt_emu);
   modport slave  (input  Din_emu, Addr_emu, wr_emu, load_emu, get_emu, run_emu, pop_emu,
                   output Dout_emu, busy_emu, done_emu, mismatch_emu, mis_cnt_emu);
`else
   modport master (output Din_emu, Addr_emu, wr_emu, load_emu, get_emu, run_emu, pop_emu,
                   input  Dout_emu, busy_emu, done_emu);
   modport slave  (input  Din_emu, Addr_emu, wr_emu, load_emu, get_emu, run_emu, pop_emu,
                   output Dout_emu, busy_emu, done_emu);
`endif
endinterface

// File: rtl/emu_burst_tester_capture_buf.sv
// rtl/emu_burst_tester_capture_buf.sv - burst capture register file (module emu_capture_buf)
// Ports: clk, rst_n (async active-low), clr + k_in (start of burst: zero pointers, latch K),
//        wr_en + wr_data (append sample), pop (advance read pointer modulo K),
//        rd_data (entry at read pointer), count (samples written), k (latched burst length).
module emu_capture_buf #(
   parameter int BURST_DEPTH = 16,
   parameter int DATA_W      = 16,
   parameter int PTR_W       = $clog2(BURST_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [PTR_W-1:0]  k_in,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [PTR_W-1:0]  count,
   output logic [PTR_W-1:0]  k
);
   localparam int IDX_W = $clog2(BURST_DEPTH);

   logic [DATA_W-1:0] mem [BURST_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_next;

   // With k still 0 (no burst yet) the read pointer stays parked on entry 0.
   assign rd_next = ((rd_ptr + PTR_W'(1)) >= k) ? '0 : rd_ptr + PTR_W'(1);
   assign rd_data = mem[rd_ptr[IDX_W-1:0]];
   assign count   = wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         k      <= '0;
         for (int i = 0; i < BURST_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         k      <= k_in;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_data;
            wr_ptr                 <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_next;
      end
   end
endmodule

// File: rtl/emu_burst_tester.sv
// rtl/emu_burst_tester.sv - co-emulation chip-test wrapper with N-byte vectors and burst capture
// Ports: clk_emu, rst_n_emu (async active-low), host (emu_burst_tester_if.slave),
//        xclk_dut (generated DUT clock), xdut_in (DUT input pins), xdut_out (DUT output pins).
// Optional: EMU_BURST_TESTER_CMP_EN adds the expected-value bank and mismatch_emu/mis_cnt_emu.
module emu_burst_tester
   import emu_tester_pkg::*;
#(
   parameter int DUT_IN_W       = 16,
   parameter int DUT_OUT_W      = 16,
   parameter int NUM_STIM_BYTES = bytes_of(DUT_IN_W),
   parameter int NUM_OUT_BYTES  = bytes_of(DUT_OUT_W),
   parameter int ADDR_W         = 4,
   parameter int BURST_DEPTH    = 16,
   parameter int HALF_PER       = 2
) (
   input  logic                 clk_emu,
   input  logic                 rst_n_emu,
   emu_burst_tester_if.slave    host,
   output logic                 xclk_dut,
   output logic [DUT_IN_W-1:0]  xdut_in,
   input  logic [DUT_OUT_W-1:0] xdut_out
);
   localparam int PTR_W  = $clog2(BURST_DEPTH) + 1;
   localparam int HC_W   = $clog2(HALF_PER) + 1;
   localparam int STIM_W = 8 * NUM_STIM_BYTES;

   state_e               state;
   logic [HC_W-1:0]      hcnt;
   logic [STIM_W-1:0]    stim;
   logic [DUT_OUT_W-1:0] live_out;
   logic [7:0]           dout;
   logic                 busy;
   logic                 done;

   cmd_e                 cmd;
   logic                 msb;
   int unsigned          lo_idx;
   logic                 last_half;
   logic                 sample;
   logic [PTR_W-1:0]     k_new;
   logic [PTR_W-1:0]     buf_k;
   logic [PTR_W-1:0]     buf_count;
   logic [DUT_OUT_W-1:0] buf_rd;
   logic [7:0]           rd_byte;

   // Host commands are only decoded in IDLE; everything is ignored mid-burst.
   assign cmd       = (state == IDLE) ? cmd_pick(host.load_emu, host.get_emu, host.run_emu,
                                                 host.pop_emu, host.wr_emu) : CMD_NONE;
   assign msb       = host.Addr_emu[ADDR_W-1];
   assign lo_idx    = 32'(host.Addr_emu[ADDR_W-2:0]);
   assign last_half = (hcnt == HC_W'(HALF_PER - 1));
   assign sample    = (state == LO) && last_half;

   // A zero or oversized count runs a full-depth burst.
   always_comb begin
      k_new = PTR_W'(BURST_DEPTH);
      if (host.Din_emu != 8'd0 && 32'(host.Din_emu) <= BURST_DEPTH)
         k_new = PTR_W'(host.Din_emu);
   end

   always_comb begin
      rd_byte = 8'd0;
      if (lo_idx < NUM_OUT_BYTES)
         rd_byte = msb ? get_byte(MAX_VEC_W'(buf_rd), lo_idx)
                       : get_byte(MAX_VEC_W'(live_out), lo_idx);
   end

   emu_capture_buf #(
      .BURST_DEPTH (BURST_DEPTH),
      .DATA_W      (DUT_OUT_W),
      .PTR_W       (PTR_W)
   ) u_buf (
      .clk     (clk_emu),
      .rst_n   (rst_n_emu),
      .clr     (cmd == CMD_RUN),
      .k_in    (k_new),
      .wr_en   (sample),
      .wr_data (xdut_out),
      .pop     (cmd == CMD_POP),
      .rd_data (buf_rd),
      .count   (buf_count),
      .k       (buf_k)
   );

   assign host.Dout_emu = dout;
   assign host.busy_emu = busy;
   assign host.done_emu = done;

`ifdef EMU_BURST_TESTER_CMP_EN
   logic [8*NUM_OUT_BYTES-1:0] expv;
   logic                       mismatch;
   logic [7:0]                 mis_cnt;

   assign host.mismatch_emu = mismatch;
   assign host.mis_cnt_emu  = mis_cnt;
`endif

   always_ff @(posedge clk_emu or negedge rst_n_emu) begin
      if (!rst_n_emu) begin
         state    <= IDLE;
         hcnt     <= '0;
         stim     <= '0;
         live_out <= '0;
         dout     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         xclk_dut <= 1'b0;
         xdut_in  <= '0;
`ifdef EMU_BURST_TESTER_CMP_EN
         expv     <= '0;
         mismatch <= 1'b0;
         mis_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               case (cmd)
                  CMD_LOAD: xdut_in  <= stim[DUT_IN_W-1:0];
                  CMD_GET:  live_out <= xdut_out;
                  CMD_RUN: begin
                     state    <= HI;
                     hcnt     <= '0;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     xclk_dut <= 1'b1;
`ifdef EMU_BURST_TESTER_CMP_EN
                     mismatch <= 1'b0;
                     mis_cnt  <= '0;
`endif
                  end
                  CMD_POP: ;
                  CMD_WR: begin
                     if (!msb) begin
                        if (lo_idx < NUM_STIM_BYTES)
                           stim <= STIM_W'(put_byte(MAX_VEC_W'(stim), lo_idx, host.Din_emu));
                     end
`ifdef EMU_BURST_TESTER_CMP_EN
                     else if (lo_idx < NUM_OUT_BYTES)
                        expv <= (8*NUM_OUT_BYTES)'(put_byte(MAX_VEC_W'(expv), lo_idx,
                                                            host.Din_emu));
`endif
                  end
                  default: dout <= rd_byte;
               endcase
            end
            HI: begin
               if (last_half) begin
                  state    <= LO;
                  hcnt     <= '0;
                  xclk_dut <= 1'b0;
               end else begin
                  hcnt <= hcnt + HC_W'(1);
               end
            end
            LO: begin
               if (last_half) begin
                  // The buffer stores this sample on the same edge.
                  live_out <= xdut_out;
                  hcnt     <= '0;
`ifdef EMU_BURST_TESTER_CMP_EN
                  if (xdut_out != expv[DUT_OUT_W-1:0]) begin
                     mismatch <= 1'b1;
                     if (mis_cnt != 8'hFF) mis_cnt <= mis_cnt + 8'd1;
                  end
`endif
                  if ((buf_count + PTR_W'(1)) < buf_k) begin
                     state    <= HI;
                     xclk_dut <= 1'b1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  hcnt <= hcnt + HC_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_emu_burst_tester.sv
// tb/tb_emu_burst_tester.sv - randomized self-checking bench for emu_burst_tester
// No ports; drives the host interface, models a counting DUT on xdut_out and checks against
// a behavioural model of stimulus bytes, live vector and capture buffer.
module tb_emu_burst_tester;
   localparam int HP = 2;
   localparam int BD = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        xclk;
   logic [15:0] xin;
   logic [15:0] xout;

   emu_burst_tester_if #(.ADDR_W(4)) host();

   // Emulated DUT: counts its own clock edges, or shows a random static value.
   int unsigned edge_cnt = 0;
   int unsigned base     = 0;
   logic        use_cnt  = 1'b0;
   logic [15:0] out_rand = 16'h0;
   always @(posedge xclk) edge_cnt <= edge_cnt + 1;
   assign xout = use_cnt ? 16'(edge_cnt - base) : out_rand;

   emu_burst_tester #(
      .DUT_IN_W    (16),
      .DUT_OUT_W   (16),
      .ADDR_W      (4),
      .BURST_DEPTH (BD),
      .HALF_PER    (HP)
   ) dut (
      .clk_emu   (clk),
      .rst_n_emu (rst_n),
      .host      (host),
      .xclk_dut  (xclk),
      .xdut_in   (xin),
      .xdut_out  (xout)
   );

   logic [7:0]  m_stim [2];
   logic [15:0] m_xin;
   logic [15:0] m_live;
   logic [15:0] m_buf [BD];
   int          m_k;
   int          m_rd;
   bit          m_buf_ok;
`ifdef EMU_BURST_TESTER_CMP_EN
   logic [15:0] m_exp;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      host.wr_emu   = 1'b0;
      host.load_emu = 1'b0;
      host.get_emu  = 1'b0;
      host.run_emu  = 1'b0;
      host.pop_emu  = 1'b0;
   endtask

   task automatic model_reset();
      m_stim[0] = 8'h0;
      m_stim[1] = 8'h0;
      m_xin     = 16'h0;
      m_live    = 16'h0;
      m_k       = 0;
      m_rd      = 0;
      for (int i = 0; i < BD; i++) m_buf[i] = 16'h0;
`ifdef EMU_BURST_TESTER_CMP_EN
      m_exp = 16'h0;
`endif
   endtask

   function automatic logic [7:0] exp_rd(input logic [3:0] a);
      int lo;
      lo = int'(a[2:0]);
      if (lo >= 2) return 8'h0;
      if (!a[3]) return m_live[lo*8 +: 8];
      return m_buf[m_rd][lo*8 +: 8];
   endfunction

   task automatic rd_check(input logic [3:0] a);
      quiet();
      host.Addr_emu = a;
      tick();
      if (a[3] && !m_buf_ok) return;
      check($sformatf("read_addr%0d", a), host.Dout_emu, exp_rd(a));
   endtask

   task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
      int lo;
      quiet();
      host.Addr_emu = a;
      host.Din_emu  = d;
      host.wr_emu   = 1'b1;
      tick();
      host.wr_emu = 1'b0;
      lo = int'(a[2:0]);
      if (!a[3]) begin
         if (lo < 2) m_stim[lo] = d;
      end
`ifdef EMU_BURST_TESTER_CMP_EN
      else if (lo < 2) m_exp[lo*8 +: 8] = d;
`endif
   endtask

   task automatic do_load();
      quiet();
      host.load_emu = 1'b1;
      tick();
      host.load_emu = 1'b0;
      m_xin = {m_stim[1], m_stim[0]};
      check("load_xdut_in", xin, m_xin);
   endtask

   task automatic do_get();
      quiet();
      use_cnt       = 1'b0;
      out_rand      = 16'($urandom);
      host.get_emu  = 1'b1;
      tick();
      host.get_emu = 1'b0;
      m_live = out_rand;
   endtask

   task automatic do_pop();
      quiet();
      host.pop_emu = 1'b1;
      tick();
      host.pop_emu = 1'b0;
      m_rd = (m_rd + 1 >= m_k) ? 0 : m_rd + 1;
   endtask

   task automatic do_burst(input logic [7:0] din, input bit noise);
      int          k;
      int          cyc;
      int unsigned e0;
      k = (din == 8'd0 || int'(din) > BD) ? BD : int'(din);
      quiet();
      use_cnt       = 1'b1;
      base          = edge_cnt;
      e0            = edge_cnt;
      host.Din_emu  = din;
      host.run_emu  = 1'b1;
      tick();
      host.run_emu = 1'b0;
      check("busy_rise", host.busy_emu, 1);
      cyc = 0;
      while (host.busy_emu && cyc < 200) begin
         if (noise) begin
            host.load_emu = 1'($urandom);
            host.get_emu  = 1'($urandom);
            host.wr_emu   = 1'($urandom);
            host.run_emu  = 1'($urandom);
            host.Addr_emu = 4'($urandom);
            host.Din_emu  = 8'($urandom);
         end
         cyc++;
         tick();
      end
      quiet();
      check("busy_cycles", cyc, 2 * HP * k);
      check("xclk_rising_edges", edge_cnt - e0, k);
      check("done_pulse_high", host.done_emu, 1);
      check("xclk_low_at_end", xclk, 0);
      check("xdut_in_held", xin, m_xin);
      tick();
      check("done_pulse_low", host.done_emu, 0);
      m_k      = k;
      m_rd     = 0;
      m_buf_ok = 1'b1;
      for (int i = 0; i < k; i++) m_buf[i] = 16'(i + 1);
      m_live = 16'(k);
`ifdef EMU_BURST_TESTER_CMP_EN
      begin
         int mc;
         mc = 0;
         for (int i = 0; i < k; i++) if (16'(i + 1) != m_exp) mc++;
         check("mismatch_flag", host.mismatch_emu, (mc > 0) ? 1 : 0);
         check("mismatch_count", host.mis_cnt_emu, mc);
      end
`endif
      use_cnt = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      quiet();
      host.Addr_emu = 4'h0;
      host.Din_emu  = 8'h0;
      model_reset();
      m_buf_ok = 1'b1;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_dout", host.Dout_emu, 0);
      check("reset_busy", host.busy_emu, 0);
      check("reset_done", host.done_emu, 0);
      check("reset_xclk", xclk, 0);
      check("reset_xdut_in", xin, 0);
      rst_n = 1'b1;
      for (int a = 0; a < 16; a++) rd_check(4'(a));
      do_pop();
      rd_check(4'h8);

      // Directed: stimulus packing and ignored bank-1 write.
      do_wr(4'h0, 8'hA5);
      do_wr(4'h1, 8'h3C);
      do_wr(4'h9, 8'hFF);
      do_load();
      check("xdut_in_3ca5", xin, 16'h3CA5);

      // Directed: 4-sample counter burst and readback with wrap.
      do_burst(8'd4, 1'b0);
      rd_check(4'h8);
      rd_check(4'h9);
      for (int p = 0; p < 4; p++) begin
         do_pop();
         rd_check(4'h8);
      end
      check("pop_wrap_entry", host.Dout_emu, 1);
      rd_check(4'h0);

      // Count clamping and ignored commands during a burst.
      do_burst(8'd0, 1'b0);
      do_burst(8'd40, 1'b0);
      do_burst(8'd4, 1'b1);
      rd_check(4'h0);
      rd_check(4'h1);
      do_load();

`ifdef EMU_BURST_TESTER_CMP_EN
      do_wr(4'h8, 8'h02);
      do_wr(4'h9, 8'h00);
      do_burst(8'd4, 1'b0);
      check("cmp_mismatch_set", host.mismatch_emu, 1);
      check("cmp_mis_cnt_3", host.mis_cnt_emu, 3);
`endif

      // Randomized mix of host operations.
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 5))
            0: do_wr(4'($urandom), 8'($urandom));
            1: do_load();
            2: do_get();
            3: rd_check(4'($urandom));
            4: begin do_pop(); rd_check(4'($urandom_range(8, 9))); end
            default: begin
               case ($urandom_range(0, 3))
                  0:       do_burst(8'd0, 1'($urandom));
                  1:       do_burst(8'($urandom_range(17, 255)), 1'($urandom));
                  default: do_burst(8'($urandom_range(1, 16)), 1'($urandom));
               endcase
               rd_check(4'($urandom));
            end
         endcase
      end

      // Reset in the middle of a burst (second high phase).
      quiet();
      host.Din_emu = 8'd4;
      host.run_emu = 1'b1;
      tick();
      host.run_emu = 1'b0;
      repeat (4) tick();
      check("midburst_xclk_high", xclk, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_busy", host.busy_emu, 0);
      check("async_reset_xclk", xclk, 0);
      check("async_reset_xdut_in", xin, 0);
      check("async_reset_dout", host.Dout_emu, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      m_buf_ok = 1'b0;
      rd_check(4'h0);
      rd_check(4'h1);
      do_load();
      do_burst(8'd3, 1'b0);
      rd_check(4'h8);
      do_pop();
      rd_check(4'h8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
